// File: rtl/regfile_pkg.sv
// Shared sizing constants and types for the 8x8 general-purpose register file.
package regfile_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int ADDR_WIDTH = 3;
    localparam int NUM_REGS   = 2 ** ADDR_WIDTH;

    typedef logic [ADDR_WIDTH-1:0] reg_addr_t;
    typedef logic [DATA_WIDTH-1:0] reg_data_t;

    typedef reg_data_t [NUM_REGS-1:0] reg_array_t;

endpackage

// File: rtl/regfile_read_port.sv
// Combinational NUM_REGS:1 read mux; one instance per ALU operand port.
module regfile_read_port
    import regfile_pkg::*;
(
    input  reg_array_t regs,
    input  reg_addr_t  sel,
    output reg_data_t  data
);

    // Select the addressed entry with zero-cycle latency; no write bypass.
    always_comb begin
        data = regs[sel];
    end

endmodule

// File: rtl/register_file.sv
// 8-entry x 8-bit register file: two combinational read ports, one
// synchronous write port. Entry 0 is an ordinary writable register.
module register_file
    import regfile_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  reg_addr_t read_reg1,
    input  reg_addr_t read_reg2,
    input  reg_addr_t write_reg,
    input  reg_data_t write_data,
    input  logic      write_enable,
    output reg_data_t read_data1,
    output reg_data_t read_data2
);

    reg_array_t regs;

    // Storage update: reset clears every entry and wins over a same-edge write.
    always_ff @(posedge clk) begin
        if (reset) begin
            regs <= '0;
        end else if (write_enable) begin
            regs[write_reg] <= write_data;
        end
    end

    regfile_read_port u_read_port1 (
        .regs (regs),
        .sel  (read_reg1),
        .data (read_data1)
    );

    regfile_read_port u_read_port2 (
        .regs (regs),
        .sel  (read_reg2),
        .data (read_data2)
    );

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: a reference model of the entries
// feeds expected values into a scoreboard queue, and each test pops and
// compares them against the DUT read ports.
module tb_register_file;

    logic       clk;
    logic       reset;
    logic [2:0] read_reg1;
    logic [2:0] read_reg2;
    logic [2:0] write_reg;
    logic [7:0] write_data;
    logic       write_enable;
    logic [7:0] read_data1;
    logic [7:0] read_data2;

    logic [7:0] model [8];
    logic [7:0] sb [$];
    logic [7:0] exp1;
    logic [7:0] exp2;
    int n_cmp = 0;
    int n_bad = 0;

    register_file dut (
        .clk          (clk),
        .reset        (reset),
        .read_reg1    (read_reg1),
        .read_reg2    (read_reg2),
        .write_reg    (write_reg),
        .write_data   (write_data),
        .write_enable (write_enable),
        .read_data1   (read_data1),
        .read_data2   (read_data2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge, landing 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model update for one edge with the current input values.
    task automatic model_edge();
        if (reset) begin
            for (int i = 0; i < 8; i++) model[i] = 8'h00;
        end else if (write_enable) begin
            model[write_reg] = write_data;
        end
    endtask

    task automatic clock_edge();
        model_edge();
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        write_enable = 1'b0;
        clock_edge();
        reset = 1'b0;
        for (int a = 0; a < 8; a++) begin
            read_reg1 = 3'(a);
            read_reg2 = 3'(7 - a);
            #1;
            sb.push_back(model[a]);
            sb.push_back(model[7 - a]);
            exp1 = sb.pop_front();
            exp2 = sb.pop_front();
            n_cmp++;
            if (read_data1 !== exp1 || exp1 !== 8'h00) begin
                n_bad++;
                $display("FAIL reset_rd1[%0d]: got %h expected %h", a, read_data1, 8'h00);
            end
            n_cmp++;
            if (read_data2 !== exp2 || exp2 !== 8'h00) begin
                n_bad++;
                $display("FAIL reset_rd2[%0d]: got %h expected %h", 7 - a, read_data2, 8'h00);
            end
        end
    endtask

    task automatic test_write_read();
        write_enable = 1'b1;
        write_reg = 3'd0;
        write_data = 8'hA5;
        clock_edge();
        write_reg = 3'd1;
        write_data = 8'h5A;
        clock_edge();
        write_enable = 1'b0;
        read_reg1 = 3'd0;
        read_reg2 = 3'd1;
        #1;
        sb.push_back(8'hA5);
        sb.push_back(8'h5A);
        exp1 = sb.pop_front();
        exp2 = sb.pop_front();
        n_cmp++;
        if (read_data1 !== exp1) begin
            n_bad++;
            $display("FAIL write_read_rd1: got %h expected %h", read_data1, exp1);
        end
        n_cmp++;
        if (read_data2 !== exp2) begin
            n_bad++;
            $display("FAIL write_read_rd2: got %h expected %h", read_data2, exp2);
        end
    endtask

    task automatic test_we_gating();
        write_enable = 1'b0;
        write_reg = 3'd0;
        write_data = 8'hFF;
        read_reg1 = 3'd0;
        for (int i = 0; i < 4; i++) begin
            clock_edge();
            sb.push_back(8'hA5);
            exp1 = sb.pop_front();
            n_cmp++;
            if (read_data1 !== exp1) begin
                n_bad++;
                $display("FAIL we_gating[%0d]: got %h expected %h", i, read_data1, exp1);
            end
        end
    endtask

    task automatic test_read_during_write();
        read_reg1 = 3'd2;
        write_reg = 3'd2;
        write_data = 8'h3C;
        write_enable = 1'b1;
        #1;
        sb.push_back(8'h00);
        exp1 = sb.pop_front();
        n_cmp++;
        if (read_data1 !== exp1) begin
            n_bad++;
            $display("FAIL rdw_before_edge: got %h expected %h", read_data1, exp1);
        end
        clock_edge();
        write_enable = 1'b0;
        sb.push_back(8'h3C);
        exp1 = sb.pop_front();
        n_cmp++;
        if (read_data1 !== exp1) begin
            n_bad++;
            $display("FAIL rdw_after_edge: got %h expected %h", read_data1, exp1);
        end
        for (int a = 0; a < 8; a++) begin
            read_reg2 = 3'(a);
            #1;
            sb.push_back(model[a]);
            exp2 = sb.pop_front();
            n_cmp++;
            if (read_data2 !== exp2) begin
                n_bad++;
                $display("FAIL rdw_others[%0d]: got %h expected %h", a, read_data2, exp2);
            end
        end
    endtask

    task automatic test_reset_priority();
        reset = 1'b1;
        write_enable = 1'b1;
        write_reg = 3'd7;
        write_data = 8'h77;
        clock_edge();
        reset = 1'b0;
        write_enable = 1'b0;
        read_reg1 = 3'd7;
        read_reg2 = 3'd0;
        #1;
        sb.push_back(8'h00);
        sb.push_back(8'h00);
        exp1 = sb.pop_front();
        exp2 = sb.pop_front();
        n_cmp++;
        if (read_data1 !== exp1) begin
            n_bad++;
            $display("FAIL rst_prio_entry7: got %h expected %h", read_data1, exp1);
        end
        n_cmp++;
        if (read_data2 !== exp2) begin
            n_bad++;
            $display("FAIL rst_prio_entry0: got %h expected %h", read_data2, exp2);
        end
        read_reg1 = 3'd1;
        #1;
        sb.push_back(8'h00);
        exp1 = sb.pop_front();
        n_cmp++;
        if (read_data1 !== exp1) begin
            n_bad++;
            $display("FAIL rst_prio_entry1: got %h expected %h", read_data1, exp1);
        end
    endtask

    task automatic test_aliasing();
        write_enable = 1'b1;
        write_reg = 3'd1;
        write_data = 8'h5A;
        clock_edge();
        write_enable = 1'b0;
        read_reg1 = 3'd1;
        read_reg2 = 3'd1;
        #1;
        sb.push_back(8'h5A);
        sb.push_back(8'h5A);
        exp1 = sb.pop_front();
        exp2 = sb.pop_front();
        n_cmp++;
        if (read_data1 !== exp1) begin
            n_bad++;
            $display("FAIL alias_rd1: got %h expected %h", read_data1, exp1);
        end
        n_cmp++;
        if (read_data2 !== exp2) begin
            n_bad++;
            $display("FAIL alias_rd2: got %h expected %h", read_data2, exp2);
        end
        // Address change with no clock edge in between.
        read_reg2 = 3'd0;
        #1;
        sb.push_back(8'h00);
        exp2 = sb.pop_front();
        n_cmp++;
        if (read_data2 !== exp2) begin
            n_bad++;
            $display("FAIL alias_comb_update: got %h expected %h", read_data2, exp2);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 64; i++) begin
            write_enable = ($urandom_range(0, 3) != 0);
            write_reg = 3'($urandom_range(0, 7));
            write_data = 8'($urandom_range(0, 255));
            read_reg1 = 3'($urandom_range(0, 7));
            read_reg2 = (i % 5 == 0) ? write_reg : 3'($urandom_range(0, 7));
            #1;
            sb.push_back(model[read_reg1]);
            sb.push_back(model[read_reg2]);
            exp1 = sb.pop_front();
            exp2 = sb.pop_front();
            n_cmp++;
            if (read_data1 !== exp1) begin
                n_bad++;
                $display("FAIL b2b_rd1[%0d] reg %0d: got %h expected %h", i, read_reg1, read_data1, exp1);
            end
            n_cmp++;
            if (read_data2 !== exp2) begin
                n_bad++;
                $display("FAIL b2b_rd2[%0d] reg %0d: got %h expected %h", i, read_reg2, read_data2, exp2);
            end
            clock_edge();
        end
        write_enable = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        read_reg1 = 3'd0;
        read_reg2 = 3'd0;
        write_reg = 3'd0;
        write_data = 8'h00;
        write_enable = 1'b0;
        for (int i = 0; i < 8; i++) model[i] = 8'hxx;
        tick();
        test_reset();
        test_write_read();
        test_we_gating();
        test_read_during_write();
        test_reset_priority();
        test_aliasing();
        test_back_to_back();
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Hard bound on total run time.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
